// File: rtl/mem_responder.sv
// ---------------------------------------------------------------------------
// mem_responder
//
// Memory-side responder for a start/write/addr/data request interface.
// A 0->1 transition of start, sampled on clk, launches one access. The
// request fields are captured on that edge. The access completes a fixed
// LATENCY clocks later. On completion a write is committed to the array or
// a read result is registered onto data_out, and done pulses for one cycle.
//
// Parameters
//   ADDR_W   address width in bits
//   DATA_W   data width in bits
//   LATENCY  clocks from request capture to completion, 1..15
//
// Ports
//   clk       clock; all state updates on the rising edge
//   reset     asynchronous, active-high reset (memory contents are retained)
//   start     request strobe; only its rising transition is a request
//   write     1 = write access, 0 = read access (captured with the request)
//   addr      access address (captured with the request)
//   data_in   write data (captured with the request)
//   data_out  last read result; held until the next read completes
//   busy      high while an access is in progress
//   done      one-cycle completion pulse
//   ovr       sticky overrun flag: a request arrived while busy
// ---------------------------------------------------------------------------
module mem_responder #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              busy,
  output logic              done,
  output logic              ovr
);

  typedef enum logic {
    IDLE,
    ACCESS
  } state_t;

  // The counter runs from LATENCY-1 down to 0, so completion falls on the
  // LATENCY-th edge after capture.
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  state_t              state_q, state_d;
  logic                start_q;
  logic [3:0]          cnt_q, cnt_d;
  logic                write_q, write_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [DATA_W-1:0]   data_out_q, data_out_d;
  logic                done_q, done_d;
  logic                ovr_q, ovr_d;
  logic                mem_we;
  logic                req;

  // Storage array. It has no reset, so contents survive a reset pulse.
  logic [DATA_W-1:0]   mem [2**ADDR_W];

  // start_q resets to 0, so a start held high through reset release is
  // seen as a rising transition on the first edge.
  assign req = start & ~start_q;

  // Next-state and datapath control.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    write_d    = write_q;
    addr_d     = addr_q;
    data_d     = data_q;
    data_out_d = data_out_q;
    done_d     = 1'b0;
    ovr_d      = ovr_q;
    mem_we     = 1'b0;

    case (state_q)
      IDLE: begin
        if (req) begin
          state_d = ACCESS;
          cnt_d   = CNT_LOAD;
          write_d = write;
          addr_d  = addr;
          data_d  = data_in;
        end
      end

      ACCESS: begin
        // A request on any ACCESS edge is rejected, including the completion
        // edge, because the FSM has not yet returned to IDLE there.
        if (req) begin
          ovr_d = 1'b1;
        end
        if (cnt_q == 4'd0) begin
          state_d = IDLE;
          done_d  = 1'b1;
          if (write_q) begin
            mem_we = 1'b1;
          end else begin
            data_out_d = mem[addr_q];
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control and captured-request registers. Reset aborts any access in
  // flight; because the array write enable depends on state_q, an aborted
  // write can never be committed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      start_q    <= 1'b0;
      cnt_q      <= 4'd0;
      write_q    <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      data_out_q <= '0;
      done_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      start_q    <= start;
      cnt_q      <= cnt_d;
      write_q    <= write_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      data_out_q <= data_out_d;
      done_q     <= done_d;
      ovr_q      <= ovr_d;
    end
  end

  // Array write port. It is deliberately outside the reset domain so that
  // memory contents are retained.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[addr_q] <= data_q;
    end
  end

  assign busy     = (state_q == ACCESS);
  assign done     = done_q;
  assign ovr      = ovr_q;
  assign data_out = data_out_q;

endmodule

// File: tb/tb_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_mem_responder
//
// Self-checking bench for mem_responder (ADDR_W=8, DATA_W=8, LATENCY=2).
// A reference model tracks the accepted request by the edge number at which
// it was captured. busy, done and completion are derived from the edge
// arithmetic (capture edge + LATENCY), with a plain array standing in for
// the memory. Directed scenarios run first, then randomized traffic.
// ---------------------------------------------------------------------------
module tb_mem_responder;

  localparam int ADDR_W  = 8;
  localparam int DATA_W  = 8;
  localparam int LATENCY = 2;

  logic              clk;
  logic              reset;
  logic              start;
  logic              write;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic              busy;
  logic              done;
  logic              ovr;

  mem_responder #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .LATENCY(LATENCY)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .write   (write),
    .addr    (addr),
    .data_in (data_in),
    .data_out(data_out),
    .busy    (busy),
    .done    (done),
    .ovr     (ovr)
  );

  // 10 ns clock period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;
  int done_seen  = 0;

  // Reference model state.
  int unsigned       edge_n;
  bit                in_flight;
  int unsigned       acc_edge;
  bit                p_write;
  logic [ADDR_W-1:0] p_addr;
  logic [DATA_W-1:0] p_data;
  bit                prev_start;
  logic [DATA_W-1:0] model_mem [256];
  logic [DATA_W-1:0] exp_dout;
  bit                exp_busy;
  bit                exp_done;
  bit                exp_ovr;

  // Addresses known to hold model-tracked data, which are safe to read.
  logic [ADDR_W-1:0] known_addr [4];

  function automatic void modelReset();
    in_flight  = 1'b0;
    prev_start = 1'b0;
    exp_dout   = '0;
    exp_busy   = 1'b0;
    exp_done   = 1'b0;
    exp_ovr    = 1'b0;
  endfunction

  // Apply the rules for one rising edge, using the inputs present at that edge.
  function automatic void modelEdge();
    bit req;
    bit busy_at_edge;
    edge_n++;
    req          = start && !prev_start;
    prev_start   = start;
    busy_at_edge = in_flight;
    exp_done     = 1'b0;
    if (in_flight && edge_n == acc_edge + LATENCY) begin
      if (p_write) model_mem[p_addr] = p_data;
      else         exp_dout = model_mem[p_addr];
      exp_done  = 1'b1;
      in_flight = 1'b0;
    end
    if (req) begin
      if (busy_at_edge) begin
        exp_ovr = 1'b1;
      end else begin
        in_flight = 1'b1;
        acc_edge  = edge_n;
        p_write   = write;
        p_addr    = addr;
        p_data    = data_in;
      end
    end
    exp_busy = in_flight;
  endfunction

  task automatic checkOutput(input string tag);
    vectors++;
    assert (busy === exp_busy) else begin
      miscompares++;
      $error("[TB] FAIL %s busy: got %b want %b", tag, busy, exp_busy);
    end
    vectors++;
    assert (done === exp_done) else begin
      miscompares++;
      $error("[TB] FAIL %s done: got %b want %b", tag, done, exp_done);
    end
    vectors++;
    assert (ovr === exp_ovr) else begin
      miscompares++;
      $error("[TB] FAIL %s ovr: got %b want %b", tag, ovr, exp_ovr);
    end
    vectors++;
    assert (data_out === exp_dout) else begin
      miscompares++;
      $error("[TB] FAIL %s data_out: got %h want %h", tag, data_out, exp_dout);
    end
  endtask

  // Drive inputs between edges, run one clock and check on the falling edge.
  task automatic applyStimulus(input bit st, input bit wr,
                               input logic [ADDR_W-1:0] ad,
                               input logic [DATA_W-1:0] dt,
                               input string tag);
    start   = st;
    write   = wr;
    addr    = ad;
    data_in = dt;
    @(posedge clk);
    modelEdge();
    @(negedge clk);
    if (done === 1'b1) done_seen++;
    checkOutput(tag);
  endtask

  task automatic idleCycles(input int n, input string tag);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, write, addr, data_in, tag);
  endtask

  // Assert reset between edges, check the asynchronous clear at once, hold
  // it across one edge and release it before the next edge.
  task automatic applyReset(input string tag);
    reset = 1'b1;
    modelReset();
    #1;
    checkOutput(tag);
    @(posedge clk);
    edge_n++;
    @(negedge clk);
    reset = 1'b0;
    checkOutput(tag);
  endtask

  task automatic checkValue(input string tag, input logic [31:0] got,
                            input logic [31:0] want);
    vectors++;
    assert (got === want) else begin
      miscompares++;
      $error("[TB] FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  initial begin
    int d0;
    reset   = 1'b1;
    start   = 1'b0;
    write   = 1'b0;
    addr    = '0;
    data_in = '0;
    edge_n  = 0;
    known_addr[0] = 8'h42;
    known_addr[1] = 8'h10;
    known_addr[2] = 8'h20;
    known_addr[3] = 8'h99;
    @(negedge clk);
    applyReset("reset");

    // Write 0x5A to 0x42: busy for two cycles, one done, data_out untouched.
    d0 = done_seen;
    applyStimulus(1'b1, 1'b1, 8'h42, 8'h5A, "wr42");
    applyStimulus(1'b0, 1'b1, 8'h42, 8'h5A, "wr42");
    idleCycles(3, "wr42");
    checkValue("wr42_done_count", 32'(done_seen - d0), 32'd1);

    // Read 0x42 back, then check that data_out holds for ten cycles.
    applyStimulus(1'b1, 1'b0, 8'h42, 8'h00, "rd42");
    idleCycles(12, "rd42_hold");
    checkValue("rd42_value", 32'(data_out), 32'h5A);

    // Hold start high for 50 cycles after one write 0x10=0xA5.
    d0 = done_seen;
    for (int i = 0; i < 50; i++) applyStimulus(1'b1, 1'b1, 8'h10, 8'hA5, "hold");
    idleCycles(2, "hold");
    checkValue("hold_done_count", 32'(done_seen - d0), 32'd1);
    checkValue("hold_ovr", 32'(ovr), 32'd0);
    applyStimulus(1'b1, 1'b0, 8'h10, 8'h00, "rd10");
    idleCycles(3, "rd10");
    checkValue("rd10_value", 32'(data_out), 32'hA5);

    // Seed 0x99, then change addr/data one cycle into a write of 0x20=0x33.
    applyStimulus(1'b1, 1'b1, 8'h99, 8'hC3, "wr99");
    idleCycles(3, "wr99");
    applyStimulus(1'b1, 1'b1, 8'h20, 8'h33, "wr20");
    applyStimulus(1'b1, 1'b1, 8'h99, 8'hFF, "wr20_chg");
    idleCycles(3, "wr20");
    applyStimulus(1'b1, 1'b0, 8'h20, 8'h00, "rd20");
    idleCycles(3, "rd20");
    checkValue("rd20_value", 32'(data_out), 32'h33);
    applyStimulus(1'b1, 1'b0, 8'h99, 8'h00, "rd99");
    idleCycles(3, "rd99");
    checkValue("rd99_value", 32'(data_out), 32'hC3);

    // A second edge on the completion edge is an overrun; only one done.
    d0 = done_seen;
    applyStimulus(1'b1, 1'b0, 8'h10, 8'h00, "ovr");
    applyStimulus(1'b0, 1'b0, 8'h10, 8'h00, "ovr");
    applyStimulus(1'b1, 1'b0, 8'h20, 8'h00, "ovr");
    idleCycles(4, "ovr");
    checkValue("ovr_done_count", 32'(done_seen - d0), 32'd1);
    checkValue("ovr_sticky", 32'(ovr), 32'd1);
    // The earliest acceptable request follows capture + LATENCY + 1.
    applyStimulus(1'b1, 1'b0, 8'h42, 8'h00, "b2b");
    applyStimulus(1'b0, 1'b0, 8'h42, 8'h00, "b2b");
    applyStimulus(1'b0, 1'b0, 8'h42, 8'h00, "b2b");
    applyStimulus(1'b1, 1'b0, 8'h20, 8'h00, "b2b");
    idleCycles(4, "b2b");
    checkValue("b2b_value", 32'(data_out), 32'h33);

    // Abort a write 0x42=0x77 with reset; 0x5A must survive.
    applyStimulus(1'b1, 1'b1, 8'h42, 8'h77, "abort");
    applyStimulus(1'b0, 1'b1, 8'h42, 8'h77, "abort");
    d0 = done_seen;
    applyReset("abort_rst");
    idleCycles(3, "abort");
    checkValue("abort_no_done", 32'(done_seen - d0), 32'd0);
    applyStimulus(1'b1, 1'b0, 8'h42, 8'h00, "rd42_after");
    idleCycles(3, "rd42_after");
    checkValue("rd42_after_value", 32'(data_out), 32'h5A);

    // Randomized traffic over addresses with known contents.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 79) == 0) begin
        applyReset("rnd_rst");
      end else begin
        applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      known_addr[$urandom_range(0, 3)], 8'($urandom),
                      "rnd");
      end
    end
    idleCycles(4, "tail");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
